// File: rtl/fifo_read_ctrl_pkg.sv
// Shared FIFO definitions: default geometry, read-side state and Gray helpers.
// The write-side controller imports the same package for its own pointer logic.
package fifo_read_ctrl_pkg;

    localparam int DEF_ADDR_W      = 3;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int PTR_MAX_W       = 16;

    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_VALID = 1'b1
    } rd_state_e;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(
        input logic [PTR_MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Upper bits are zero-extended, so folding from the top is width-safe.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(
        input logic [PTR_MAX_W-1:0] g
    );
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing clock domains.
// Also instanced on the write side for the read pointer.
module ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: empty/level, RAM read issue,
// and a valid/ready output stage holding one fetched word.
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rempty,
    output logic [ADDR_W:0]   rd_level
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] r_rptr_gray;
    rd_state_e        r_state;

    logic [PTR_W-1:0] w_wptr_sync;
    logic [PTR_W-1:0] w_wbin_sync;
    logic [PTR_W-1:0] w_rbin_next;
    logic [PTR_W-1:0] w_rgray_next;
    logic             w_valid;
    logic             w_empty;
    logic             w_re;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr_gray),
        .q   (w_wptr_sync)
    );

    assign w_wbin_sync  = PTR_W'(gray2bin(PTR_MAX_W'(w_wptr_sync)));
    assign w_rbin_next  = r_rbin + 1'b1;
    assign w_rgray_next = PTR_W'(bin2gray(PTR_MAX_W'(w_rbin_next)));

    // Pointer advances at issue, so empty never counts a word in flight.
    assign w_valid = (r_state == RD_VALID);
    assign w_empty = (r_rptr_gray == w_wptr_sync);
    assign w_re    = !w_empty && (!w_valid || rd_ready);

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
        end else if (w_re) begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= w_rgray_next;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state <= RD_EMPTY;
        end else begin
            unique case (r_state)
                RD_EMPTY: begin
                    if (w_re) r_state <= RD_VALID;
                end
                RD_VALID: begin
                    if (!w_re && rd_ready) r_state <= RD_EMPTY;
                end
                default: r_state <= RD_EMPTY;
            endcase
        end
    end

    assign rptr_gray = r_rptr_gray;
    assign ram_re    = w_re;
    assign ram_addr  = r_rbin[ADDR_W-1:0];
    assign rd_valid  = w_valid;
    assign rd_data   = w_valid ? ram_q : '0;
    assign rempty    = w_empty;
    assign rd_level  = w_wbin_sync - r_rbin;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: RAM + write-pointer model, scoreboard queue.
module tb_fifo_read_ctrl;

    logic        rclk = 1'b0;
    logic        rrst;
    logic [3:0]  wptr_gray;
    logic [3:0]  rptr_gray;
    logic        ram_re;
    logic [2:0]  ram_addr;
    logic [31:0] ram_q;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rempty;
    logic [3:0]  rd_level;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [8];
    logic [3:0]  wbin;
    logic [31:0] exp_q [$];
    int          fetched;

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (ram_re) ram_q <= mem[ram_addr];
    end

    fifo_read_ctrl #(.ADDR_W(3), .DATA_W(32), .SYNC_STAGES(2)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr_gray (wptr_gray),
        .rptr_gray (rptr_gray),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rempty    (rempty),
        .rd_level  (rd_level)
    );

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic push_word(input logic [31:0] d);
        mem[wbin[2:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 4'd1;
        wptr_gray = gray(wbin);
    endtask

    task automatic cyc;
        @(negedge rclk);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rempty !== 1'b1 || ram_re !== 1'b0 ||
            rptr_gray !== 4'b0000 || rd_data !== 32'd0 || rd_level !== 4'd0) begin
            errors++;
            $display("FAIL reset: valid=%b empty=%b re=%b rptr=%b data=%h lvl=%0d",
                     rd_valid, rempty, ram_re, rptr_gray, rd_data, rd_level);
        end
        cyc();
        rrst = 1'b0;
    endtask

    task automatic test_one_word;
        cyc();
        push_word(32'hA5A5_0001);
        cyc(); #1;
        checks++;
        if (rempty !== 1'b1 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL one_sync1: empty=%b re=%b need 1/0", rempty, ram_re);
        end
        cyc(); #1;
        checks++;
        if (rempty !== 1'b0 || ram_re !== 1'b1 || ram_addr !== 3'd0) begin
            errors++;
            $display("FAIL one_issue: empty=%b re=%b addr=%0d need 0/1/0",
                     rempty, ram_re, ram_addr);
        end
        cyc(); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001 || rptr_gray !== 4'b0001 ||
            ram_re !== 1'b0) begin
            errors++;
            $display("FAIL one_data: valid=%b data=%h rptr=%b re=%b",
                     rd_valid, rd_data, rptr_gray, ram_re);
        end
        rd_ready = 1'b1;
        void'(exp_q.pop_front());
        cyc(); #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || rempty !== 1'b1) begin
            errors++;
            $display("FAIL one_drain: valid=%b data=%h empty=%b", rd_valid, rd_data, rempty);
        end
        rd_ready = 1'b0;
        fetched = 1;
    endtask

    task automatic test_backpressure;
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) begin
            cyc();
            w[i] = $urandom;
            push_word(w[i]);
        end
        repeat (5) cyc();
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== w[0] || rd_level !== 4'd2 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h need %h lvl=%0d re=%b",
                     rd_valid, rd_data, w[0], rd_level, ram_re);
        end
        cyc(); #1;
        checks++;
        if (rd_data !== w[0]) begin
            errors++;
            $display("FAIL bp_stable: data=%h need %h", rd_data, w[0]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            rd_ready = 1'b1;
            #1;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== w[i]) begin
                errors++;
                $display("FAIL bp_word%0d: valid=%b data=%h need %h", i, rd_valid, rd_data, w[i]);
            end
            void'(exp_q.pop_front());
        end
        cyc(); #1;
        checks++;
        if (rd_valid !== 1'b0 || rempty !== 1'b1 || rd_level !== 4'd0) begin
            errors++;
            $display("FAIL bp_end: valid=%b empty=%b lvl=%0d", rd_valid, rempty, rd_level);
        end
        rd_ready = 1'b0;
        fetched = 4;
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        bit seen_wrap_addr;
        bit seen_gray;
        bit got;
        seen_wrap_addr = 0;
        seen_gray = 0;
        rd_ready = 1'b1;
        for (int p = 0; p < 10; p++) begin
            cyc();
            d = {8'hC0, 8'(p), 16'($urandom)};
            push_word(d);
            got = 0;
            for (int t = 0; t < 12 && !got; t++) begin
                cyc(); #1;
                if (ram_re) begin
                    checks++;
                    if (ram_addr !== 3'(fetched)) begin
                        errors++;
                        $display("FAIL wrap_addr: addr=%0d need %0d", ram_addr, fetched % 8);
                    end
                    if (fetched == 8) seen_wrap_addr = (ram_addr === 3'd0);
                    if (fetched == 7) begin
                        checks++;
                        if (rptr_gray !== 4'b0100) begin
                            errors++;
                            $display("FAIL wrap_g7: rptr=%b need 0100", rptr_gray);
                        end
                    end
                    fetched++;
                end
                if (rd_valid) begin
                    got = 1;
                    checks++;
                    if (rd_data !== d || rptr_gray !== gray(4'(fetched))) begin
                        errors++;
                        $display("FAIL wrap_data%0d: data=%h need %h rptr=%b need %b",
                                 p, rd_data, d, rptr_gray, gray(4'(fetched)));
                    end
                    if (fetched == 8 && rptr_gray === 4'b1100) seen_gray = 1;
                    void'(exp_q.pop_front());
                end
            end
            if (!got) begin
                errors++;
                checks++;
                $display("FAIL wrap_timeout: pair %0d valid=0 need 1", p);
            end
        end
        cyc(); #1;
        checks++;
        if (!seen_wrap_addr || !seen_gray || rempty !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: addr_wrap=%0b gray_1100=%0b empty=%b valid=%b",
                     seen_wrap_addr, seen_gray, rempty, rd_valid);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_midstream;
        for (int i = 0; i < 5; i++) begin
            cyc();
            push_word($urandom);
        end
        repeat (5) cyc();
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_level !== 4'd4) begin
            errors++;
            $display("FAIL rst_pre: valid=%b lvl=%0d need 1/4", rd_valid, rd_level);
        end
        #2;
        rrst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || rptr_gray !== 4'd0 ||
            ram_addr !== 3'd0 || rempty !== 1'b1 || rd_level !== 4'd0 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: valid=%b data=%h rptr=%b addr=%0d empty=%b lvl=%0d",
                     rd_valid, rd_data, rptr_gray, ram_addr, rempty, rd_level);
        end
        wbin = '0;
        wptr_gray = '0;
        exp_q.delete();
        fetched = 0;
        cyc();
        cyc();
        rrst = 1'b0;
    endtask

    task automatic test_race;
        logic [31:0] a;
        logic [31:0] b;
        bit hit;
        a = $urandom;
        b = $urandom;
        rd_ready = 1'b1;
        cyc();
        push_word(a);
        hit = 0;
        for (int t = 0; t < 6 && !hit; t++) begin
            cyc(); #1;
            hit = ram_re;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL race_issue: re=0 need 1");
        end
        push_word(b);
        cyc(); #1;
        checks++;
        if (ram_re !== 1'b0 || rd_valid !== 1'b1 || rd_data !== a) begin
            errors++;
            $display("FAIL race_gap: re=%b valid=%b data=%h need 0/1/%h", ram_re, rd_valid, rd_data, a);
        end
        cyc(); #1;
        checks++;
        if (ram_re !== 1'b1 || rd_valid !== 1'b0 || ram_addr !== 3'd1) begin
            errors++;
            $display("FAIL race_refetch: re=%b valid=%b addr=%0d need 1/0/1", ram_re, rd_valid, ram_addr);
        end
        cyc(); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== b || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL race_word2: valid=%b data=%h need %h re=%b", rd_valid, rd_data, b, ram_re);
        end
        cyc(); #1;
        checks++;
        if (rd_valid !== 1'b0 || rempty !== 1'b1) begin
            errors++;
            $display("FAIL race_end: valid=%b empty=%b", rd_valid, rempty);
        end
        exp_q.delete();
        fetched = 2;
        rd_ready = 1'b0;
    endtask

    task automatic test_random_stream;
        int consumed;
        int written;
        bit prev_hold;
        logic [31:0] prev_data;
        int budget;
        consumed = 0;
        written = 0;
        prev_hold = 0;
        prev_data = '0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (c < 300 && (written - consumed) < 7 && $urandom_range(0, 2) != 0) begin
                push_word($urandom);
                written++;
            end
            rd_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
            #1;
            if (prev_hold) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    errors++;
                    $display("FAIL rnd_stable: valid=%b data=%h need %h", rd_valid, rd_data, prev_data);
                end
            end
            if (!rd_valid && rd_data !== 32'd0) begin
                errors++;
                $display("FAIL rnd_gate: data=%h need 0", rd_data);
            end
            if (rd_valid && rd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: data=%h with empty scoreboard", rd_data);
                end else if (rd_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rnd_data: data=%h need %h", rd_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                consumed++;
            end
            prev_hold = rd_valid && !rd_ready;
            prev_data = rd_data;
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            cyc(); #1;
            if (rd_valid) begin
                void'(exp_q.pop_front());
                consumed++;
            end
            budget++;
        end
        cyc(); #1;
        checks++;
        if (consumed != written || rempty !== 1'b1 || rd_valid !== 1'b0 || rd_level !== 4'd0) begin
            errors++;
            $display("FAIL rnd_end: consumed=%0d need %0d empty=%b valid=%b lvl=%0d",
                     consumed, written, rempty, rd_valid, rd_level);
        end
    endtask

    initial begin
        rrst = 1'b1;
        wptr_gray = '0;
        wbin = '0;
        rd_ready = 1'b0;
        fetched = 0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_one_word();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        test_race();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
